// File: rtl/bus_controller.sv
// Hardwired control unit for the 16-bit basic computer: a sequence counter
// (T0..T6) decoded with the latched opcode/indirect bit into bus and register strobes.
module bus_controller #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [W-1:0] ir,
  input  logic         dr_zero,
  output logic [2:0]   bus_sel,
  output logic         ar_ld,
  output logic         ar_inc,
  output logic         pc_ld,
  output logic         pc_inc,
  output logic         dr_ld,
  output logic         dr_inc,
  output logic         ac_ld,
  output logic         ac_clr,
  output logic         ac_inc,
  output logic         ir_ld,
  output logic         tr_ld,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [2:0]   alu_op,
  output logic [3:0]   sc,
  output logic         halted
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6
  } step_t;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_AR   = 3'b001;
  localparam logic [2:0] BUS_PC   = 3'b010;
  localparam logic [2:0] BUS_DR   = 3'b011;
  localparam logic [2:0] BUS_AC   = 3'b100;
  localparam logic [2:0] BUS_IR   = 3'b101;
  localparam logic [2:0] BUS_MEM  = 3'b111;

  step_t      step_q, step_d;
  logic [2:0] d_q, d_d;
  logic       i_q, i_d;
  logic       halted_q, halted_d;

  // Address-field bits that never steer control; folded here so they read as used.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[10], ir[8:6], ir[4:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q   <= T0;
      d_q      <= 3'd0;
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      d_q      <= d_d;
      i_q      <= i_d;
      halted_q <= halted_d;
    end
  end

  // run is a level request, not a handshake: it is only looked at in T0, and
  // once a fetch has started the instruction always runs to its final step.
  always_comb begin
    step_d   = step_q;
    d_d      = d_q;
    i_d      = i_q;
    halted_d = halted_q;
    bus_sel  = BUS_NONE;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ac_clr   = 1'b0;
    ac_inc   = 1'b0;
    ir_ld    = 1'b0;
    tr_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    alu_op   = 3'b000;

    if (halted_q) begin
      step_d = T0;
    end else begin
      case (step_q)
        T0: begin
          if (run) begin
            bus_sel = BUS_PC;
            ar_ld   = 1'b1;
            step_d  = T1;
          end
        end
        T1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          step_d  = T2;
        end
        T2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
          d_d     = ir[14:12];
          i_d     = ir[15];
          step_d  = T3;
        end
        T3: begin
          if (d_q == 3'd7) begin
            step_d = T0;
            if (!i_q) begin
              if (ir[11]) begin
                ac_clr = 1'b1;
              end else if (ir[9]) begin
                alu_op = 3'b100;
                ac_ld  = 1'b1;
              end else if (ir[5]) begin
                ac_inc = 1'b1;
              end
              if (ir[0]) halted_d = 1'b1;
            end
          end else begin
            step_d = T4;
            if (i_q) begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              ar_ld   = 1'b1;
            end
          end
        end
        T4: begin
          step_d = T0;
          case (d_q)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              dr_ld   = 1'b1;
              step_d  = T5;
            end
            3'd3: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
            end
            3'd4: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
            end
            3'd5: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
              step_d  = T5;
            end
            default: step_d = T0;
          endcase
        end
        T5: begin
          step_d = T0;
          case (d_q)
            3'd0: begin alu_op = 3'b001; ac_ld = 1'b1; end
            3'd1: begin alu_op = 3'b010; ac_ld = 1'b1; end
            3'd2: begin alu_op = 3'b011; ac_ld = 1'b1; end
            3'd5: begin bus_sel = BUS_AR; pc_ld = 1'b1; end
            3'd6: begin dr_inc = 1'b1; step_d = T6; end
            default: step_d = T0;
          endcase
        end
        T6: begin
          // dr_zero already reflects the T5 increment here.
          bus_sel = BUS_DR;
          mem_wr  = 1'b1;
          pc_inc  = dr_zero;
          step_d  = T0;
        end
        default: step_d = T0;
      endcase
    end

    if (!rst_n) begin
      bus_sel = BUS_NONE;
      ar_ld   = 1'b0;
      ar_inc  = 1'b0;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      dr_ld   = 1'b0;
      dr_inc  = 1'b0;
      ac_ld   = 1'b0;
      ac_clr  = 1'b0;
      ac_inc  = 1'b0;
      ir_ld   = 1'b0;
      tr_ld   = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      alu_op  = 3'b000;
    end
  end

  assign sc     = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: directed instruction table, random instructions and
// hand-written reset/halt sequences, all scored against a per-instruction step model.
module tb_bus_controller;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         run;
  logic [W-1:0] ir;
  logic         dr_zero;
  logic [2:0]   bus_sel;
  logic         ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
  logic         ac_ld, ac_clr, ac_inc, ir_ld, tr_ld, mem_rd, mem_wr;
  logic [2:0]   alu_op;
  logic [3:0]   sc;
  logic         halted;

  bus_controller #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .dr_zero(dr_zero),
    .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld),
    .ac_clr(ac_clr), .ac_inc(ac_inc), .ir_ld(ir_ld), .tr_ld(tr_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .sc(sc),
    .halted(halted)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Observed vector: {bus_sel, 13 strobes, alu_op, sc, halted}
  logic [23:0] obs;
  assign obs = {bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld,
                ac_clr, ac_inc, ir_ld, tr_ld, mem_rd, mem_wr, alu_op, sc, halted};

  localparam logic [23:0] NONE     = 24'h0;
  localparam logic [23:0] M_AR_LD  = 24'h1 << 20;
  localparam logic [23:0] M_AR_INC = 24'h1 << 19;
  localparam logic [23:0] M_PC_LD  = 24'h1 << 18;
  localparam logic [23:0] M_PC_INC = 24'h1 << 17;
  localparam logic [23:0] M_DR_LD  = 24'h1 << 16;
  localparam logic [23:0] M_DR_INC = 24'h1 << 15;
  localparam logic [23:0] M_AC_LD  = 24'h1 << 14;
  localparam logic [23:0] M_AC_CLR = 24'h1 << 13;
  localparam logic [23:0] M_AC_INC = 24'h1 << 12;
  localparam logic [23:0] M_IR_LD  = 24'h1 << 11;
  localparam logic [23:0] M_MEM_RD = 24'h1 << 9;
  localparam logic [23:0] M_MEM_WR = 24'h1 << 8;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [15:0] instr;
    logic        dz;
    int          cycles;
    logic        halts;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [23:0] cv(logic [2:0] bus, logic [23:0] strobes,
                                     logic [2:0] alu, int step, logic h);
    logic [23:0] v;
    v        = strobes;
    v[23:21] = bus;
    v[7:5]   = alu;
    v[4:1]   = 4'(step);
    v[0]     = h;
    return v;
  endfunction

  // Reference model: the micro-operation list of one instruction, one entry per cycle.
  function automatic void model_push(logic [15:0] instr, logic dz);
    logic [2:0] d;
    logic       i;
    d = instr[14:12];
    i = instr[15];
    exp_q.push_back(cv(3'b010, M_AR_LD, 3'b000, 0, 1'b0));
    exp_q.push_back(cv(3'b111, M_MEM_RD | M_IR_LD | M_PC_INC, 3'b000, 1, 1'b0));
    exp_q.push_back(cv(3'b101, M_AR_LD, 3'b000, 2, 1'b0));
    if (d == 3'd7) begin
      if (i)              exp_q.push_back(cv(3'b000, NONE, 3'b000, 3, 1'b0));
      else if (instr[11]) exp_q.push_back(cv(3'b000, M_AC_CLR, 3'b000, 3, 1'b0));
      else if (instr[9])  exp_q.push_back(cv(3'b000, M_AC_LD, 3'b100, 3, 1'b0));
      else if (instr[5])  exp_q.push_back(cv(3'b000, M_AC_INC, 3'b000, 3, 1'b0));
      else                exp_q.push_back(cv(3'b000, NONE, 3'b000, 3, 1'b0));
      return;
    end
    exp_q.push_back(i ? cv(3'b111, M_MEM_RD | M_AR_LD, 3'b000, 3, 1'b0)
                      : cv(3'b000, NONE, 3'b000, 3, 1'b0));
    case (d)
      3'd0, 3'd1, 3'd2: begin
        exp_q.push_back(cv(3'b111, M_MEM_RD | M_DR_LD, 3'b000, 4, 1'b0));
        exp_q.push_back(cv(3'b000, M_AC_LD, d + 3'd1, 5, 1'b0));
      end
      3'd3: exp_q.push_back(cv(3'b100, M_MEM_WR, 3'b000, 4, 1'b0));
      3'd4: exp_q.push_back(cv(3'b001, M_PC_LD, 3'b000, 4, 1'b0));
      3'd5: begin
        exp_q.push_back(cv(3'b010, M_MEM_WR | M_AR_INC, 3'b000, 4, 1'b0));
        exp_q.push_back(cv(3'b001, M_PC_LD, 3'b000, 5, 1'b0));
      end
      default: begin
        exp_q.push_back(cv(3'b111, M_MEM_RD | M_DR_LD, 3'b000, 4, 1'b0));
        exp_q.push_back(cv(3'b000, M_DR_INC, 3'b000, 5, 1'b0));
        exp_q.push_back(cv(3'b011, M_MEM_WR | (dz ? M_PC_INC : NONE), 3'b000, 6, 1'b0));
      end
    endcase
  endfunction

  function automatic int spec_cycles(logic [15:0] instr);
    logic [2:0] d;
    d = instr[14:12];
    if (d == 3'd7) return 4;
    if (d == 3'd3 || d == 3'd4) return 5;
    if (d == 3'd6) return 7;
    return 6;
  endfunction

  // scoreboard
  task automatic check_cycle(input string name);
    logic [23:0] e;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s got %06h exp none (extra cycle)", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL %s got %06h exp %06h", name, obs, e);
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, want);
    end
  endtask

  // driver tasks
  task automatic idle_cycles(input int n);
    run = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(cv(3'b000, NONE, 3'b000, 0, 1'b0));
      check_cycle("idle");
      @(posedge clk); #1;
    end
  endtask

  task automatic halted_cycles(input int n);
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      ir      = 16'($urandom);
      dr_zero = 1'($urandom_range(0, 1));
      exp_q.push_back(cv(3'b000, NONE, 3'b000, 0, 1'b1));
      check_cycle("halted_idle");
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_pulse(input logic [23:0] during);
    rst_n = 1'b0;
    exp_q.push_back(during);
    check_cycle("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("rst_sc", int'(sc), 0);
    check_val("rst_halted", int'(halted), 0);
    idle_cycles(1);
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic dz,
                           input int exp_cycles, input logic exp_halt);
    int cyc;
    ir      = instr;
    dr_zero = dz;
    run     = 1'b1;
    model_push(instr, dz);
    cyc = 0;
    do begin
      check_cycle($sformatf("i%04h_t%0d", instr, cyc));
      @(posedge clk); #1;
      cyc++;
      run = 1'($urandom_range(0, 1));
    end while (sc != 4'd0 && cyc < 12);
    exp_q.delete();
    check_val($sformatf("i%04h_cycles", instr), cyc, exp_cycles);
    check_val($sformatf("i%04h_halted", instr), int'(halted), int'(exp_halt));
  endtask

  initial begin
    tbl[0]  = '{16'h7800, 1'b0, 4, 1'b0};  // CLA
    tbl[1]  = '{16'h1005, 1'b0, 6, 1'b0};  // ADD direct
    tbl[2]  = '{16'hA010, 1'b1, 6, 1'b0};  // LDA indirect
    tbl[3]  = '{16'h6020, 1'b1, 7, 1'b0};  // ISZ, DR becomes zero
    tbl[4]  = '{16'h6020, 1'b0, 7, 1'b0};  // ISZ, DR nonzero
    tbl[5]  = '{16'h5030, 1'b0, 6, 1'b0};  // BSA
    tbl[6]  = '{16'h3040, 1'b0, 5, 1'b0};  // STA
    tbl[7]  = '{16'h4050, 1'b1, 5, 1'b0};  // BUN
    tbl[8]  = '{16'h0060, 1'b0, 6, 1'b0};  // AND
    tbl[9]  = '{16'hF000, 1'b0, 4, 1'b0};  // I/O
    tbl[10] = '{16'h7200, 1'b0, 4, 1'b0};  // CMA
    tbl[11] = '{16'h7020, 1'b0, 4, 1'b0};  // INC
    tbl[12] = '{16'h7A20, 1'b0, 4, 1'b0};  // CLA wins over CMA/INC
    tbl[13] = '{16'h7220, 1'b0, 4, 1'b0};  // CMA wins over INC
    tbl[14] = '{16'hB070, 1'b0, 5, 1'b0};  // STA indirect
    tbl[15] = '{16'h7001, 1'b0, 4, 1'b1};  // HLT

    rst_n   = 1'b0;
    run     = 1'b1;
    ir      = 16'h1234;
    dr_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(cv(3'b000, NONE, 3'b000, 0, 1'b0));
    check_cycle("reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;

    idle_cycles(3);

    for (int t = 0; t < 16; t++)
      run_instr(tbl[t].instr, tbl[t].dz, tbl[t].cycles, tbl[t].halts);

    halted_cycles(10);
    reset_pulse(cv(3'b000, NONE, 3'b000, 0, 1'b1));

    // Reset during ADD T4: instruction abandoned, no ac_ld afterwards
    ir      = 16'h1005;
    dr_zero = 1'b0;
    run     = 1'b1;
    model_push(16'h1005, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_cycle($sformatf("add_abort_t%0d", k));
      @(posedge clk); #1;
    end
    exp_q.delete();
    reset_pulse(cv(3'b000, NONE, 3'b000, 4, 1'b0));
    idle_cycles(4);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] instr;
      logic        dz;
      logic        halts;
      instr = 16'($urandom_range(0, 16'hffff));
      dz    = 1'($urandom_range(0, 1));
      halts = (instr[15:12] == 4'h7) && instr[0];
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      run_instr(instr, dz, spec_cycles(instr), halts);
      if (halts) begin
        halted_cycles(2);
        reset_pulse(cv(3'b000, NONE, 3'b000, 0, 1'b1));
      end
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
